// File: rtl/snake_pkg.sv
// Shared definitions for the snake game controller.
//   - state_t       : controller FSM states
//   - DIR_*         : committed direction encodings (2 bits)
//   - REQ_*         : one-hot direction request codes from the keypad
//   - dir_req_t     : decoded direction request {valid, dir}
//   - opposite_dir  : direction pointing the other way
//   - decode_req    : one-hot request -> dir_req_t
//   - bcd_inc       : packed two-digit BCD increment
package snake_pkg;

    typedef enum logic [2:0] {
        ST_MENU   = 3'd0,
        ST_INIT   = 3'd1,
        ST_PLAY   = 3'd2,
        ST_PAUSED = 3'd3,
        ST_OVER   = 3'd4
    } state_t;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [4:0] REQ_UP    = 5'b00010;
    localparam logic [4:0] REQ_LEFT  = 5'b00100;
    localparam logic [4:0] REQ_DOWN  = 5'b01000;
    localparam logic [4:0] REQ_RIGHT = 5'b10000;

    typedef struct packed {
        logic       valid;
        logic [1:0] dir;
    } dir_req_t;

    // Up/down and left/right differ only in bit 1 of the encoding.
    function automatic logic [1:0] opposite_dir(input logic [1:0] d);
        return d ^ 2'd2;
    endfunction

    function automatic dir_req_t decode_req(input logic [4:0] r);
        dir_req_t q;
        case (r)
            REQ_UP:    q = '{valid: 1'b1, dir: DIR_UP};
            REQ_LEFT:  q = '{valid: 1'b1, dir: DIR_LEFT};
            REQ_DOWN:  q = '{valid: 1'b1, dir: DIR_DOWN};
            REQ_RIGHT: q = '{valid: 1'b1, dir: DIR_RIGHT};
            default:   q = '{valid: 1'b0, dir: DIR_UP};
        endcase
        return q;
    endfunction

    // {tens, units}; the game ends at 99 so tens never overflows.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector.
//   clk    : clock
//   resetn : asynchronous active-low reset (stored level cleared to 0)
//   din    : level input
//   pulse  : high for the cycle in which din is 1 and was 0 at the last edge
module edge_detect (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic pulse
);

    logic din_prev_r;

    // Remember the level seen at the previous clock edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            din_prev_r <= 1'b0;
        end else begin
            din_prev_r <= din;
        end
    end

    assign pulse = din & ~din_prev_r;

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game controller: menu/init/play/pause/over sequencing, move timing,
// direction arbitration, BCD scoring and speed-up.
//   clk, resetn            : clock, asynchronous active-low reset
//   start, pause           : key levels, rising edges used
//   tick                   : one-cycle frame pulse
//   dir_req[4:0]           : one-hot direction request
//   good_/bad_collision    : collision levels from the datapath
//   inmenu/ingame/game_over/won : state flags
//   clear                  : high for the whole INIT phase
//   step                   : one-cycle move pulse, coincident with the tick
//   dir[1:0]               : committed direction
//   grow                   : one-cycle pulse the cycle after an apple
//   score[7:0]             : packed BCD score
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int TICKS_PER_STEP = 3,
    parameter int MIN_TICKS      = 1,
    parameter int SPEEDUP_EVERY  = 4,
    parameter int INIT_CYCLES    = 641
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       pause,
    input  logic       tick,
    input  logic [4:0] dir_req,
    input  logic       good_collision,
    input  logic       bad_collision,
    output logic       inmenu,
    output logic       ingame,
    output logic       game_over,
    output logic       won,
    output logic       clear,
    output logic       step,
    output logic [1:0] dir,
    output logic       grow,
    output logic [7:0] score
);

    // Highest level before the period would fall below MIN_TICKS.
    localparam int MAX_LEVEL = (TICKS_PER_STEP > MIN_TICKS) ? (TICKS_PER_STEP - MIN_TICKS) : 0;

    state_t      state_r;
    state_t      state_nxt_s;

    logic        start_pe_s;
    logic        pause_pe_s;
    logic        good_pe_s;
    logic        bad_pe_s;

    logic [15:0] init_cnt_r;
    logic [15:0] tick_cnt_r;
    logic [15:0] level_r;
    logic [15:0] apple_mod_r;
    logic [15:0] period_raw_s;
    logic [15:0] period_s;
    logic [1:0]  dir_r;
    logic [1:0]  pend_dir_r;
    logic        pend_valid_r;
    logic [7:0]  score_r;
    logic        won_r;
    logic        grow_r;

    dir_req_t    req_s;
    logic        req_ok_s;
    logic        in_play_s;
    logic        step_s;
    logic        enter_init_s;
    logic        score_event_s;
    logic [7:0]  score_nxt_s;
    logic        win_s;

    edge_detect u_ed_start (.clk(clk), .resetn(resetn), .din(start),          .pulse(start_pe_s));
    edge_detect u_ed_pause (.clk(clk), .resetn(resetn), .din(pause),          .pulse(pause_pe_s));
    edge_detect u_ed_good  (.clk(clk), .resetn(resetn), .din(good_collision), .pulse(good_pe_s));
    edge_detect u_ed_bad   (.clk(clk), .resetn(resetn), .din(bad_collision),  .pulse(bad_pe_s));

    assign in_play_s     = (state_r == ST_PLAY);
    assign enter_init_s  = (state_r == ST_MENU) && start_pe_s;
    // A simultaneous bad collision cancels the apple.
    assign score_event_s = in_play_s && good_pe_s && !bad_pe_s;
    assign score_nxt_s   = bcd_inc(score_r);
    assign win_s         = score_event_s && (score_nxt_s == 8'h99);
    assign req_s         = decode_req(dir_req);
    assign req_ok_s      = req_s.valid && (req_s.dir != opposite_dir(dir_r));

    // Move period for the current speed level, never below MIN_TICKS or 1.
    always_comb begin
        period_raw_s = 16'(TICKS_PER_STEP) - level_r;
        if (period_raw_s > 16'(MIN_TICKS)) begin
            period_s = period_raw_s;
        end else begin
            period_s = 16'(MIN_TICKS);
        end
        if (period_s == 16'd0) begin
            period_s = 16'd1;
        end else begin
            period_s = period_s;
        end
    end

    // '>=' lets a speed-up that shortens the period mid-count still step.
    assign step_s = in_play_s && tick && (tick_cnt_r >= (period_s - 16'd1));

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_MENU;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_MENU: begin
                if (start_pe_s) begin
                    state_nxt_s = ST_INIT;
                end else begin
                    state_nxt_s = ST_MENU;
                end
            end
            ST_INIT: begin
                if (init_cnt_r == 16'(INIT_CYCLES - 1)) begin
                    state_nxt_s = ST_PLAY;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_PLAY: begin
                if (bad_pe_s || win_s) begin
                    state_nxt_s = ST_OVER;
                end else if (pause_pe_s) begin
                    state_nxt_s = ST_PAUSED;
                end else begin
                    state_nxt_s = ST_PLAY;
                end
            end
            ST_PAUSED: begin
                if (pause_pe_s) begin
                    state_nxt_s = ST_PLAY;
                end else begin
                    state_nxt_s = ST_PAUSED;
                end
            end
            ST_OVER: begin
                if (start_pe_s) begin
                    state_nxt_s = ST_MENU;
                end else begin
                    state_nxt_s = ST_OVER;
                end
            end
            default: state_nxt_s = ST_MENU;
        endcase
    end

    // Game datapath: init timer, move timer, direction, score and speed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            init_cnt_r   <= 16'd0;
            tick_cnt_r   <= 16'd0;
            level_r      <= 16'd0;
            apple_mod_r  <= 16'd0;
            dir_r        <= DIR_RIGHT;
            pend_dir_r   <= DIR_RIGHT;
            pend_valid_r <= 1'b0;
            score_r      <= 8'h00;
            won_r        <= 1'b0;
            grow_r       <= 1'b0;
        end else begin
            grow_r <= score_event_s;

            if (state_r == ST_INIT) begin
                init_cnt_r <= init_cnt_r + 16'd1;
            end else begin
                init_cnt_r <= 16'd0;
            end

            if (enter_init_s) begin
                tick_cnt_r   <= 16'd0;
                level_r      <= 16'd0;
                apple_mod_r  <= 16'd0;
                dir_r        <= DIR_RIGHT;
                pend_dir_r   <= DIR_RIGHT;
                pend_valid_r <= 1'b0;
                score_r      <= 8'h00;
                won_r        <= 1'b0;
            end else begin
                if (in_play_s && tick) begin
                    if (step_s) begin
                        tick_cnt_r <= 16'd0;
                    end else begin
                        tick_cnt_r <= tick_cnt_r + 16'd1;
                    end
                end

                // A request arriving in the step cycle itself is the latest one.
                if (step_s) begin
                    if (req_ok_s) begin
                        dir_r <= req_s.dir;
                    end else if (pend_valid_r) begin
                        dir_r <= pend_dir_r;
                    end
                    pend_valid_r <= 1'b0;
                end else if (in_play_s && req_ok_s) begin
                    pend_dir_r   <= req_s.dir;
                    pend_valid_r <= 1'b1;
                end

                if (score_event_s) begin
                    score_r <= score_nxt_s;
                    if (win_s) begin
                        won_r <= 1'b1;
                    end
                    if (apple_mod_r >= 16'(SPEEDUP_EVERY - 1)) begin
                        apple_mod_r <= 16'd0;
                        if (level_r < 16'(MAX_LEVEL)) begin
                            level_r <= level_r + 16'd1;
                        end
                    end else begin
                        apple_mod_r <= apple_mod_r + 16'd1;
                    end
                end
            end
        end
    end

    assign inmenu    = (state_r == ST_MENU);
    assign ingame    = (state_r == ST_PLAY) || (state_r == ST_PAUSED);
    assign game_over = (state_r == ST_OVER);
    assign clear     = (state_r == ST_INIT);
    assign step      = step_s;
    assign dir       = dir_r;
    assign grow      = grow_r;
    assign score     = score_r;
    assign won       = won_r;

endmodule
